audio_frame_serializer: RTL and testbench

//  Parametrised codec DAC serializer, successor to the fixed 16-bit stereo DSP-mode shifter.

---
 rtl/audio_frame_serializer.sv | 145 ++++++++++++++
 tb/tb_audio_frame_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_serializer.sv
// Codec DAC serializer: buffers PCM frames in a small FIFO and shifts one frame per
// sample-clock tick onto dacdat/daclrc, timed by falling edges of the codec bit clock.
module audio_frame_serializer #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE       = 0,
  parameter int HOLD_ON_UR = 1
) (
  input  logic                         clk25,
  input  logic                         reset25,
  input  logic                         codec_bclk_i,
  input  logic                         audio_sample_clk,
  input  logic [NUM_CH*SAMPLE_W-1:0]   s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         dacdat,
  output logic                         daclrc,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         underrun,
  input  logic                         underrun_clr,
  output logic                         frame_err
);
  localparam int D   = (MODE == 1) ? 1 : 0;
  localparam int L   = NUM_CH*SLOT_W + D;
  localparam int KW  = $clog2(L+1);
  localparam int FW  = NUM_CH*SAMPLE_W;
  localparam int SW  = NUM_CH*SLOT_W;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int PAD = SLOT_W - SAMPLE_W;
  localparam logic IDLE_LRC = (MODE == 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic          bclk_q, sclk_q, fall, rise, start, pop, push, empty, start_pending;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [FW-1:0] held, frame_sel;
  logic [SW-1:0] slotted, sr;
  logic [KW-1:0] k;

  function automatic logic lrc_at(input logic [KW-1:0] kv);
    case (MODE)
      1:       return kv >= KW'(SLOT_W);
      2:       return kv <  KW'(SLOT_W);
      default: return kv == '0;
    endcase
  endfunction

  assign fall    = bclk_q & ~codec_bclk_i;
  assign rise    = ~sclk_q & audio_sample_clk;
  assign empty   = (fifo_level == '0);
  assign start   = fall & start_pending;
  assign pop     = start & ~empty;
  assign s_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push    = s_valid & s_ready;
  assign busy    = (state == SHIFT);

  // Underrun substitutes the held frame or silence.
  assign frame_sel = pop ? mem[rd_ptr] : ((HOLD_ON_UR != 0) ? held : '0);

  // Left-justify each sample in its slot; pad bits below stay zero.
  always_comb begin
    slotted = '0;
    for (int c = 0; c < NUM_CH; c++)
      slotted[c*SLOT_W+PAD +: SAMPLE_W] = frame_sel[c*SAMPLE_W +: SAMPLE_W];
  end

  always_ff @(posedge clk25) begin
    if (reset25) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)                                        state_nxt = SHIFT;
    else if (fall && state == SHIFT && k == KW'(L))   state_nxt = IDLE;
  end

  always_ff @(posedge clk25) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk25) begin
    if (reset25) begin
      bclk_q        <= 1'b0;
      sclk_q        <= 1'b0;
      start_pending <= 1'b0;
      frame_err     <= 1'b0;
      underrun      <= 1'b0;
      fifo_level    <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      held          <= '0;
      sr            <= '0;
      k             <= '0;
      dacdat        <= 1'b0;
      daclrc        <= 1'b0;
    end else begin
      bclk_q    <= codec_bclk_i;
      sclk_q    <= audio_sample_clk;
      frame_err <= rise & busy;

      if (rise)       start_pending <= 1'b1;
      else if (start) start_pending <= 1'b0;

      if (start && empty)    underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        held   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase

      // A start always wins, aborting any frame still in flight.
      if (start) begin
        k      <= KW'(1);
        dacdat <= (D == 1) ? 1'b0 : slotted[SW-1];
        sr     <= (D == 1) ? slotted : (slotted << 1);
        daclrc <= lrc_at('0);
      end else if (fall && busy) begin
        if (k == KW'(L)) begin
          k      <= '0;
          dacdat <= 1'b0;
          daclrc <= IDLE_LRC;
        end else begin
          k      <= k + KW'(1);
          dacdat <= sr[SW-1];
          sr     <= sr << 1;
          daclrc <= lrc_at(k);
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_frame_serializer.sv
// Bench for audio_frame_serializer: four configurations share one stimulus stream and are
// compared against per-frame bit/lrc formulas and a queue model of the frame FIFO.
module tb_audio_frame_serializer;
  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic        reset25, codec_bclk_i, audio_sample_clk, s_valid, underrun_clr;
  logic [31:0] s_data;
  logic [3:0]  dat, lrc, bsy, rdy, ur, fe;
  logic [2:0]  lvl [4];

  audio_frame_serializer #(.SLOT_W(16), .MODE(0), .HOLD_ON_UR(1)) u0 (
    .clk25(clk25), .reset25(reset25), .codec_bclk_i(codec_bclk_i), .audio_sample_clk(audio_sample_clk),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]), .dacdat(dat[0]), .daclrc(lrc[0]), .busy(bsy[0]),
    .fifo_level(lvl[0]), .underrun(ur[0]), .underrun_clr(underrun_clr), .frame_err(fe[0]));
  audio_frame_serializer #(.SLOT_W(16), .MODE(1), .HOLD_ON_UR(1)) u1 (
    .clk25(clk25), .reset25(reset25), .codec_bclk_i(codec_bclk_i), .audio_sample_clk(audio_sample_clk),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]), .dacdat(dat[1]), .daclrc(lrc[1]), .busy(bsy[1]),
    .fifo_level(lvl[1]), .underrun(ur[1]), .underrun_clr(underrun_clr), .frame_err(fe[1]));
  audio_frame_serializer #(.SLOT_W(24), .MODE(2), .HOLD_ON_UR(1)) u2 (
    .clk25(clk25), .reset25(reset25), .codec_bclk_i(codec_bclk_i), .audio_sample_clk(audio_sample_clk),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[2]), .dacdat(dat[2]), .daclrc(lrc[2]), .busy(bsy[2]),
    .fifo_level(lvl[2]), .underrun(ur[2]), .underrun_clr(underrun_clr), .frame_err(fe[2]));
  audio_frame_serializer #(.SLOT_W(16), .MODE(0), .HOLD_ON_UR(0)) u3 (
    .clk25(clk25), .reset25(reset25), .codec_bclk_i(codec_bclk_i), .audio_sample_clk(audio_sample_clk),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[3]), .dacdat(dat[3]), .daclrc(lrc[3]), .busy(bsy[3]),
    .fifo_level(lvl[3]), .underrun(ur[3]), .underrun_clr(underrun_clr), .frame_err(fe[3]));

  typedef struct { logic [31:0] frame; logic [31:0] exp0; logic [47:0] exp2; } vec_t;
  vec_t tbl [4];

  int          n_chk = 0, n_pass = 0;
  logic [31:0] q [$];
  logic [31:0] held, cur [4];
  logic        ur_m;
  logic [3:0]  mbusy;
  logic [63:0] cd [4], cl [4], cb [4];

  function automatic int md(int d);   return (d == 1) ? 1 : ((d == 2) ? 2 : 0); endfunction
  function automatic int sl(int d);   return (d == 2) ? 24 : 16; endfunction
  function automatic int flen(int d); return 2*sl(d) + ((md(d) == 1) ? 1 : 0); endfunction

  function automatic logic exp_dat(int d, logic [31:0] f, int k);
    int dl, j, ch, b;
    dl = (md(d) == 1) ? 1 : 0;
    if (k < dl || k >= flen(d)) return 1'b0;
    j  = k - dl;
    ch = j / sl(d);
    b  = sl(d) - 1 - (j % sl(d));
    if (b < sl(d) - 16) return 1'b0;
    return f[(1-ch)*16 + b - (sl(d) - 16)];
  endfunction

  function automatic logic exp_lrc(int d, int k);
    if (k >= flen(d)) return (md(d) == 1);
    case (md(d))
      1:       return k >= sl(d);
      2:       return k <  sl(d);
      default: return k == 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", nm, got, exp);
  endtask

  task automatic bclk_cycle();
    codec_bclk_i = 1'b1; @(posedge clk25); #1;
    codec_bclk_i = 1'b0; @(posedge clk25); #1;
  endtask

  task automatic push_f(input logic [31:0] f);
    logic ok;
    ok = (q.size() < 4);
    chk("s_ready_before_push", {63'd0, rdy[0]}, {63'd0, ok});
    s_data = f; s_valid = 1'b1;
    @(posedge clk25); #1;
    s_valid = 1'b0;
    if (ok) q.push_back(f);
    chk("fifo_level_after_push", {61'd0, lvl[0]}, 64'(q.size()));
  endtask

  task automatic tick();
    audio_sample_clk = 1'b1; @(posedge clk25); #1;
    chk("frame_err_pulse", {60'd0, fe}, {60'd0, mbusy});
    audio_sample_clk = 1'b0; @(posedge clk25); #1;
    chk("frame_err_one_cycle", {60'd0, fe}, 64'd0);
  endtask

  task automatic run(input int n);
    logic [63:0] ed, el, eb;
    if (q.size() > 0) begin
      held = q.pop_front();
      for (int d = 0; d < 4; d++) cur[d] = held;
    end else begin
      ur_m = 1'b1;
      for (int d = 0; d < 4; d++) cur[d] = (d == 3) ? 32'd0 : held;
    end
    for (int d = 0; d < 4; d++) begin cd[d] = '0; cl[d] = '0; cb[d] = '0; end
    for (int i = 0; i < n; i++) begin
      bclk_cycle();
      for (int d = 0; d < 4; d++) begin
        cd[d][i] = dat[d]; cl[d][i] = lrc[d]; cb[d][i] = bsy[d];
      end
    end
    for (int d = 0; d < 4; d++) begin
      ed = '0; el = '0; eb = '0;
      for (int i = 0; i < n; i++) begin
        ed[i] = exp_dat(d, cur[d], i);
        el[i] = exp_lrc(d, i);
        eb[i] = (i < flen(d));
      end
      chk($sformatf("dacdat_stream_u%0d", d), cd[d], ed);
      chk($sformatf("daclrc_stream_u%0d", d), cl[d], el);
      chk($sformatf("busy_stream_u%0d", d), cb[d], eb);
      mbusy[d] = (n <= flen(d));
    end
    chk("underrun_flag", {60'd0, ur}, {60'd0, {4{ur_m}}});
    chk("fifo_level_after_frame", {61'd0, lvl[0]}, 64'(q.size()));
  endtask

  task automatic clear_ur();
    underrun_clr = 1'b1; @(posedge clk25); #1;
    underrun_clr = 1'b0;
    ur_m = 1'b0;
    chk("underrun_cleared", {60'd0, ur}, 64'd0);
  endtask

  task automatic chk_reset_state(input string nm);
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_u%0d", nm, d), {56'd0, dat[d], lrc[d], bsy[d], ur[d], fe[d], lvl[d]},
          64'd0);
    chk({nm, "_s_ready"}, {60'd0, rdy}, 64'hF);
    q.delete(); held = '0; ur_m = 1'b0; mbusy = '0;
  endtask

  initial begin
    logic [31:0] s0;
    logic [47:0] s2;
    tbl[0] = '{32'hA5C30F0F, 32'hA5C30F0F, 48'hA5C3000F0F00};
    tbl[1] = '{32'h8001FFFF, 32'h8001FFFF, 48'h800100FFFF00};
    tbl[2] = '{32'hFFFF0001, 32'hFFFF0001, 48'hFFFF00000100};
    tbl[3] = '{32'h12345678, 32'h12345678, 48'h123400567800};

    reset25 = 1'b1; codec_bclk_i = 1'b0; audio_sample_clk = 1'b0;
    s_valid = 1'b0; s_data = '0; underrun_clr = 1'b0;
    repeat (3) @(posedge clk25);
    #1 reset25 = 1'b0;
    @(posedge clk25); #1;
    chk_reset_state("reset");

    for (int t = 0; t < 4; t++) begin
      push_f(tbl[t].frame);
      tick();
      run(50);
      for (int i = 0; i < 32; i++) s0[31-i] = cd[0][i];
      for (int i = 0; i < 48; i++) s2[47-i] = cd[2][i];
      chk($sformatf("tbl%0d_dsp_bits", t), {32'd0, s0}, {32'd0, tbl[t].exp0});
      chk($sformatf("tbl%0d_lj24_bits", t), {16'd0, s2}, {16'd0, tbl[t].exp2});
    end

    // FIFO empty after 1234/5678: held copy resent, silence on the no-hold instance.
    tick();
    run(50);
    clear_ur();

    for (int i = 0; i < 5; i++) push_f(32'hC0DE0000 | 32'(i));
    chk("fifo_full_level", {61'd0, lvl[0]}, 64'd4);
    chk("fifo_full_s_ready", {63'd0, rdy[0]}, 64'd0);
    tick();
    run(50);
    chk("fifo_pop_level", {61'd0, lvl[0]}, 64'd3);
    chk("fifo_pop_s_ready", {63'd0, rdy[0]}, 64'd1);

    for (int it = 0; it < 12; it++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) push_f($urandom);
      tick();
      run(50);
      if ($urandom_range(0, 3) == 0) clear_ur();
    end

    // Second request mid-frame flags an error and restarts from bit 0.
    push_f($urandom);
    push_f($urandom);
    tick();
    run(10);
    tick();
    run(50);

    push_f($urandom);
    tick();
    run(10);
    reset25 = 1'b1; @(posedge clk25); #1;
    chk_reset_state("reset_mid_frame");
    reset25 = 1'b0;
    @(posedge clk25); #1;
    chk_reset_state("after_reset_release");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
